// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the D-extension floating-point datapath: rounding-mode
// encodings, fflags bit positions, binary64 field geometry and the operand
// class enumeration produced by fp_d_unpack.
// -----------------------------------------------------------------------------
package fp_pkg;

    // Rounding modes as carried on the rm field. DYN never reaches the ALU.
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Bit positions inside the 5-bit fflags vector {NV, DZ, OF, UF, NX}.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // binary64 geometry.
    localparam int D_WIDTH  = 64;
    localparam int D_EXP_W  = 11;
    localparam int D_FRAC_W = 52;
    localparam int D_BIAS   = 1023;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

endpackage

// File: rtl/fp_d_unpack.sv
// -----------------------------------------------------------------------------
// fp_d_unpack
// Combinational binary64 field splitter and classifier, shared by the
// D-extension operations.
//   d        : binary64 operand
//   sign     : sign bit
//   exponent : biased 11-bit exponent
//   fraction : 52-bit stored fraction (no hidden bit)
//   cls      : ZERO / SUB / NORM / INF / NAN
// -----------------------------------------------------------------------------
module fp_d_unpack
    import fp_pkg::*;
(
    input  logic [D_WIDTH-1:0]  d,
    output logic                sign,
    output logic [D_EXP_W-1:0]  exponent,
    output logic [D_FRAC_W-1:0] fraction,
    output fp_class_e           cls
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    assign sign      = d[D_WIDTH-1];
    assign exponent  = d[D_WIDTH-2 -: D_EXP_W];
    assign fraction  = d[D_FRAC_W-1:0];
    assign exp_zero  = (exponent == '0);
    assign exp_ones  = &exponent;
    assign frac_zero = (fraction == '0);

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via the default first) so no latch is inferred.
        cls = FP_NORM;
        if (exp_zero) begin
            cls = frac_zero ? FP_ZERO : FP_SUB;
        end else if (exp_ones) begin
            cls = frac_zero ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fp_cvt_w_d.sv
// -----------------------------------------------------------------------------
// fp_cvt_w_d
// binary64 -> 32-bit integer converter (FCVT.W.D / FCVT.WU.D). Three stages
// (unpack, align, round/saturate) behind an input register, with valid/ready
// on both sides. An operation accepted on edge N is presented after edge N+3.
//
// Build option: FP_CVT_WU_EN -- when defined, in_unsigned selects the WU
// conversion; otherwise every conversion is signed and in_unsigned is ignored.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : operation present          in_ready  : can accept
//   in_d         : binary64 operand           in_rm     : rounding mode
//   in_unsigned  : WU conversion select       in_tag    : opaque tag
//   out_valid    : result present             out_ready : consumer accepts
//   out_w        : integer result             out_flags : {NV,DZ,OF,UF,NX}
//   out_tag      : tag of this result
// -----------------------------------------------------------------------------
module fp_cvt_w_d
    import fp_pkg::*;
#(
    parameter int ID_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_d,
    input  logic [2:0]         in_rm,
    input  logic               in_unsigned,
    input  logic [ID_W-1:0]    in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_w,
    output logic [4:0]         out_flags,
    output logic [ID_W-1:0]    out_tag
);

    // ---------------- pipeline state ----------------
    logic                s1_valid, s2_valid, s3_valid;

    logic [D_WIDTH-1:0]  s1_d;
    logic [2:0]          s1_rm;
    logic                s1_uns;
    logic [ID_W-1:0]     s1_tag;

    logic                s2_sign;
    logic [D_EXP_W-1:0]  s2_exp;
    logic [D_FRAC_W-1:0] s2_frac;
    fp_class_e           s2_cls;
    logic [2:0]          s2_rm;
    logic                s2_uns;
    logic [ID_W-1:0]     s2_tag;

    logic                s3_sign, s3_nan, s3_inf, s3_ovf;
    logic [31:0]         s3_mag;
    logic                s3_guard, s3_sticky;
    logic [2:0]          s3_rm;
    logic                s3_uns;
    logic [ID_W-1:0]     s3_tag;

    // ---------------- flow control ----------------
    // Each register can load when it is empty or its content moves on.
    logic out_rdy, s3_rdy, s2_rdy;

    assign out_rdy  = !out_valid || out_ready;
    assign s3_rdy   = !s3_valid  || out_rdy;
    assign s2_rdy   = !s2_valid  || s3_rdy;
    assign in_ready = !s1_valid  || s2_rdy;

    // ---------------- stage 1: unpack ----------------
    logic                u_sign;
    logic [D_EXP_W-1:0]  u_exp;
    logic [D_FRAC_W-1:0] u_frac;
    fp_class_e           u_cls;

    fp_d_unpack u_unpack (
        .d        (s1_d),
        .sign     (u_sign),
        .exponent (u_exp),
        .fraction (u_frac),
        .cls      (u_cls)
    );

    // ---------------- stage 2: align ----------------
    logic signed [12:0] e_unb;
    logic [5:0]         shamt;
    logic [84:0]        wide;
    logic               a_nan, a_inf, a_ovf, a_guard, a_sticky;
    logic [31:0]        a_mag;

    assign e_unb = signed'({2'b00, s2_exp}) - signed'(13'(D_BIAS));
    // e+1 = exp-1022, and 1022 mod 64 = 62; the low six bits are exact
    // whenever e+1 lies in 0..32, the only range where the shift is used.
    assign shamt = s2_exp[5:0] - 6'd62;
    // With the significand left-shifted by e+1, the binary point sits
    // between bits 53 and 52: integer part above, guard at 52, sticky below.
    assign wide  = {32'b0, (s2_cls == FP_NORM), s2_frac} << shamt;

    always_comb begin
        a_nan    = 1'b0;
        a_inf    = 1'b0;
        a_ovf    = 1'b0;
        a_mag    = '0;
        a_guard  = 1'b0;
        a_sticky = 1'b0;
        case (s2_cls)
            FP_NAN:  a_nan = 1'b1;
            FP_INF:  a_inf = 1'b1;
            FP_ZERO: ;
            default: begin
                if (e_unb >= 13'sd32) begin
                    a_ovf = 1'b1;
                end else if (e_unb < -13'sd1) begin
                    // Below 0.5 in magnitude: only the sticky bit survives.
                    a_sticky = 1'b1;
                end else begin
                    a_mag    = wide[84:53];
                    a_guard  = wide[52];
                    a_sticky = |wide[51:0];
                end
            end
        endcase
    end

    // ---------------- stage 3: round / saturate ----------------
    logic        rnd_up;
    logic [32:0] mag_r;
    logic        nv;
    logic [31:0] res_w;
    logic [4:0]  res_flags;

    always_comb begin
        rnd_up = 1'b0;
        case (s3_rm)
            RM_RNE:  rnd_up = s3_guard && (s3_sticky || s3_mag[0]);
            RM_RDN:  rnd_up = s3_sign && (s3_guard || s3_sticky);
            RM_RUP:  rnd_up = !s3_sign && (s3_guard || s3_sticky);
            RM_RMM:  rnd_up = s3_guard;
            default: rnd_up = 1'b0;  // RTZ and the reserved encodings
        endcase
    end

    assign mag_r = {1'b0, s3_mag} + {32'b0, rnd_up};

`ifndef FP_CVT_WU_EN
    logic unused_uns;
    assign unused_uns = s3_uns;
`endif

    always_comb begin
        nv    = 1'b0;
        res_w = '0;
        if (s3_nan) begin
            nv    = 1'b1;
            res_w = 32'h7FFF_FFFF;
        end else if (s3_inf || s3_ovf) begin
            nv    = 1'b1;
            res_w = s3_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (!s3_sign) begin
            if (mag_r > 33'h0_7FFF_FFFF) begin
                nv    = 1'b1;
                res_w = 32'h7FFF_FFFF;
            end else begin
                res_w = mag_r[31:0];
            end
        end else begin
            if (mag_r > 33'h0_8000_0000) begin
                nv    = 1'b1;
                res_w = 32'h8000_0000;
            end else begin
                res_w = -mag_r[31:0];
            end
        end
`ifdef FP_CVT_WU_EN
        if (s3_uns) begin
            nv    = 1'b0;
            res_w = '0;
            if (s3_nan) begin
                nv    = 1'b1;
                res_w = 32'hFFFF_FFFF;
            end else if (s3_inf || s3_ovf) begin
                nv    = 1'b1;
                res_w = s3_sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
            end else if (!s3_sign) begin
                if (mag_r[32]) begin
                    nv    = 1'b1;
                    res_w = 32'hFFFF_FFFF;
                end else begin
                    res_w = mag_r[31:0];
                end
            end else begin
                // A negative value is representable only if it rounds to 0.
                nv = (mag_r != '0);
            end
        end
`endif
        res_flags          = '0;
        res_flags[FLAG_NV] = nv;
        res_flags[FLAG_DZ] = 1'b0;
        res_flags[FLAG_OF] = 1'b0;
        res_flags[FLAG_UF] = 1'b0;
        res_flags[FLAG_NX] = !nv && (s3_guard || s3_sticky);
    end

    // ---------------- control and output registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // stage samples the values from before this edge.
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_w     <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else begin
            if (in_ready) s1_valid  <= in_valid;
            if (s2_rdy)   s2_valid  <= s1_valid;
            if (s3_rdy)   s3_valid  <= s2_valid;
            if (out_rdy)  out_valid <= s3_valid;
            if (out_rdy && s3_valid) begin
                out_w     <= res_w;
                out_flags <= res_flags;
                out_tag   <= s3_tag;
            end
        end
    end

    // ---------------- internal data registers ----------------
    // NOTE: internal payload registers are not reset; they are qualified by
    // the stage valid bits, which are.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_d   <= in_d;
            s1_rm  <= in_rm;
            s1_uns <= in_unsigned;
            s1_tag <= in_tag;
        end
        if (s2_rdy && s1_valid) begin
            s2_sign <= u_sign;
            s2_exp  <= u_exp;
            s2_frac <= u_frac;
            s2_cls  <= u_cls;
            s2_rm   <= s1_rm;
            s2_uns  <= s1_uns;
            s2_tag  <= s1_tag;
        end
        if (s3_rdy && s2_valid) begin
            s3_sign   <= s2_sign;
            s3_nan    <= a_nan;
            s3_inf    <= a_inf;
            s3_ovf    <= a_ovf;
            s3_mag    <= a_mag;
            s3_guard  <= a_guard;
            s3_sticky <= a_sticky;
            s3_rm     <= s2_rm;
            s3_uns    <= s2_uns;
            s3_tag    <= s2_tag;
        end
    end

endmodule
